// File: rtl/snn_img_sender.sv
// snn_img_sender: initiator side of the SNN image/result link.
// Reads a binary image one pixel per address from a 1-bit synchronous RAM.
// Packs each group of 8 pixels into a byte, with the lowest address in the LSB.
// Sends the bytes through uart_tx, then waits on uart_rx for the classification byte.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for start; digit holds the last result
// FETCH      | 9 cycles: present 8 addresses, capture 8 pixels one cycle late
// SEND       | packed byte ready; pulse tx_start as soon as uart_tx is idle
// WAIT_TX    | byte on the wire; the first cycle is skipped while tx_rdy settles
// WAIT_RES   | all bytes sent; wait for the result byte or for the timeout

module snn_img_sender #(
    parameter int NUM_BYTES = 98,
    parameter int TO_W      = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  mem_addr,
    input  logic        mem_q,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_rdy,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  digit
);

    localparam int BC_W = $clog2(NUM_BYTES + 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [9:0]      LAST_ADDR = 10'(NUM_BYTES * 8 - 1);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
    // The counter is compared one step early, so err fires on the edge where it reaches all-ones.
    localparam logic [TO_W-1:0] TO_PRE    = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RES
    } state_t;

    state_t state, state_nxt;

    logic [BC_W-1:0] byte_cnt;
    logic [3:0]      bit_cnt;
    logic [6:0]      shreg;
    logic [TO_W-1:0] to_cnt;

    logic fetch_last;
    logic tx_first;
    logic last_byte;
    logic to_hit;
    logic rx_ok;

    assign fetch_last = (bit_cnt == 4'd8);
    assign tx_first   = (bit_cnt == 4'd0);
    assign last_byte  = (byte_cnt == LAST_BYTE);
    assign to_hit     = (to_cnt == TO_PRE);
    assign rx_ok      = (rx_data <= 8'd9);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_last) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (tx_rdy) state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (!tx_first && tx_rdy) begin
                    state_nxt = last_byte ? S_WAIT_RES : S_FETCH;
                end
            end
            S_WAIT_RES: begin
                if (rx_rdy || to_hit) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state; tx_start is gated by tx_rdy so it can never fire into a busy UART.
    always_comb begin
        busy     = (state != S_IDLE);
        tx_start = (state == S_SEND) && tx_rdy;
    end

    // Datapath: address and counters, pixel packing, timeout, and the result and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= 10'd0;
            tx_data  <= 8'h00;
            byte_cnt <= '0;
            bit_cnt  <= 4'd0;
            shreg    <= 7'd0;
            to_cnt   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            digit    <= 4'hF;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr <= 10'd0;
                        byte_cnt <= '0;
                        bit_cnt  <= 4'd0;
                    end
                end
                S_FETCH: begin
                    if (bit_cnt < 4'd8) begin
                        if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + 10'd1;
                    end
                    if (bit_cnt != 4'd0) begin
                        shreg <= {mem_q, shreg[6:1]};
                    end
                    if (fetch_last) begin
                        tx_data <= {mem_q, shreg};
                        bit_cnt <= 4'd0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_SEND: begin
                    bit_cnt <= 4'd0;
                end
                S_WAIT_TX: begin
                    if (tx_first) begin
                        bit_cnt <= 4'd1;
                    end else if (tx_rdy) begin
                        byte_cnt <= byte_cnt + BC_ONE;
                        bit_cnt  <= 4'd0;
                        if (last_byte) to_cnt <= '0;
                    end
                end
                S_WAIT_RES: begin
                    to_cnt <= to_cnt + TO_ONE;
                    if (rx_rdy) begin
                        if (rx_ok) begin
                            digit <= rx_data[3:0];
                            done  <= 1'b1;
                        end else begin
                            digit <= 4'hF;
                            err   <= 1'b1;
                        end
                    end else if (to_hit) begin
                        digit <= 4'hF;
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_img_sender.sv
// Testbench for snn_img_sender.
// Models the image RAM, uart_tx (with 10-cycle frames) and the result side of the SNN board.
// Expected bytes and digits are queued when an image is loaded and are compared against what reaches uart_tx.
module tb_snn_img_sender;

    localparam int NB    = 98;
    localparam int TOW   = 6;
    localparam int FRAME = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mem_q = 1'b0;
    logic       tx_rdy = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] mem_addr;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy, done, err;
    logic [3:0] digit;

    snn_img_sender #(.NUM_BYTES(NB), .TO_W(TOW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_q(mem_q),
        .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .rx_rdy(rx_rdy), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err), .digit(digit)
    );

    always #10 clk = ~clk;

    logic img [0:1023];
    int errors = 0, checks = 0;
    int cyc = 0, n_start = 0, start_viol = 0, tx_cnt = 0, rdy_cyc = 0;
    int max_addr = 0, done_hi = 0, err_hi = 0, err_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int res_q[$];

    // Image RAM (one-cycle read latency) and uart_tx model; the UART is not reset, so an in-flight byte completes.
    always @(posedge clk) begin
        cyc++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        mem_q <= img[mem_addr];
        if (tx_start) begin
            if (!tx_rdy) start_viol++;
            obs_q.push_back(tx_data);
            n_start++;
            tx_rdy <= 1'b0;
            tx_cnt <= FRAME - 1;
        end else if (!tx_rdy) begin
            if (tx_cnt == 0) begin
                tx_rdy <= 1'b1;
                rdy_cyc = cyc;
            end else begin
                tx_cnt <= tx_cnt - 1;
            end
        end
    end

    // Pulse counters for done/err, sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_hi++;
        if (err) begin
            err_hi++;
            err_cyc = cyc;
        end
    end

    function automatic logic [7:0] pack_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = img[8*k+i];
        return b;
    endfunction

    task automatic load_expected();
        exp_q.delete();
        obs_q.delete();
        for (int k = 0; k < NB; k++) exp_q.push_back(pack_byte(k));
        n_start = 0;
        done_hi = 0;
        err_hi  = 0;
    endtask

    task automatic drive_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok, output int busy_lo);
        busy_lo = 0;
        ok = 1'b0;
        for (int t = 0; t < 6000 && !ok; t++) begin
            @(negedge clk);
            if (!busy) busy_lo++;
            ok = (n_start >= n) && tx_rdy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        if (tx_start !== 1'b0)  begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        if (digit !== 4'hF)     begin errors++; $display("FAIL reset_digit: got %h want F", digit); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    // Board model: counts set pixels in the received bytes and replies with that count mod 10.
    task automatic test_snn_result();
        int pix[7] = '{3, 100, 250, 400, 555, 700, 783};
        bit ok;
        int blo, ones, t;
        logic [7:0] e, o;
        for (int a = 0; a < 1024; a++) img[a] = 1'b0;
        for (int i = 0; i < 7; i++) img[pix[i]] = 1'b1;
        load_expected();
        res_q.push_back(7);
        drive_start();
        wait_bytes(NB, ok, blo);
        checks++;
        if (!ok) begin errors++; $display("FAIL snn_tx_timeout: got %0d bytes want %0d", n_start, NB); end
        ones = 0;
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL snn_byte[%0d]: got none want %h", k, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                for (int i = 0; i < 8; i++) ones += int'(o[i]);
                if (o !== e) begin errors++; $display("FAIL snn_byte[%0d]: got %h want %h", k, o, e); end
            end
        end
        repeat (4) @(negedge clk);
        send_rx(8'(ones % 10));
        t = 0;
        while (done_hi == 0 && t < 50) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        checks += 4;
        if (done_hi !== 1) begin errors++; $display("FAIL snn_done_pulse: got %0d cycles want 1", done_hi); end
        if (err_hi !== 0)  begin errors++; $display("FAIL snn_err: got %0d cycles want 0", err_hi); end
        if (int'(digit) !== res_q.pop_front()) begin errors++; $display("FAIL snn_digit: got %0d want 7", digit); end
        if (busy !== 1'b0) begin errors++; $display("FAIL snn_busy: got %b want 0", busy); end
    endtask

    task automatic test_all_zero_timeout();
        bit ok;
        int blo, t;
        logic [7:0] e, o;
        for (int a = 0; a < 1024; a++) img[a] = 1'b0;
        load_expected();
        start_viol = 0;
        drive_start();
        wait_bytes(NB, ok, blo);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL zero_tx_timeout: got %0d bytes want %0d", n_start, NB); end
        if (blo !== 0) begin errors++; $display("FAIL zero_busy_drop: got %0d low cycles want 0", blo); end
        if (start_viol !== 0) begin errors++; $display("FAIL zero_start_while_busy_uart: got %0d want 0", start_viol); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL zero_byte[%0d]: got none want 00", k);
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL zero_byte[%0d]: got %h want %h", k, o, e); end
            end
        end
        repeat (3) @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL zero_wait_res_busy: got %b want 1", busy); end
        if (n_start !== NB) begin errors++; $display("FAIL zero_start_count: got %0d want %0d", n_start, NB); end
        t = 0;
        while (err_hi == 0 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        checks += 5;
        // tx_rdy rises in the last WAIT_TX cycle; WAIT_RES starts one edge later and then lasts 2^6-1 = 63 cycles.
        if (err_cyc - rdy_cyc !== 64) begin errors++; $display("FAIL timeout_latency: got %0d want 64", err_cyc - rdy_cyc); end
        if (err_hi !== 1)  begin errors++; $display("FAIL timeout_err_pulse: got %0d cycles want 1", err_hi); end
        if (done_hi !== 0) begin errors++; $display("FAIL timeout_done: got %0d want 0", done_hi); end
        if (digit !== 4'hF) begin errors++; $display("FAIL timeout_digit: got %h want F", digit); end
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
    endtask

    task automatic test_ignore_while_busy();
        int blo, t;
        bit ok;
        logic [7:0] e, o;
        for (int a = 0; a < 1024; a++) img[a] = 1'($urandom_range(0, 1));
        load_expected();
        drive_start();
        blo = 0;
        ok = 1'b0;
        for (t = 0; t < 6000 && !ok; t++) begin
            @(negedge clk);
            if (!busy) blo++;
            rx_data = 8'h03;
            rx_rdy  = (n_start < NB) && (t % 50 < 20);
            start   = (n_start < NB) && (t % 97 == 13);
            ok = (n_start >= NB) && tx_rdy;
        end
        rx_rdy = 1'b0;
        start  = 1'b0;
        checks += 4;
        if (!ok) begin errors++; $display("FAIL ignore_tx_timeout: got %0d bytes want %0d", n_start, NB); end
        if (blo !== 0) begin errors++; $display("FAIL ignore_busy_drop: got %0d want 0", blo); end
        if (done_hi !== 0 || err_hi !== 0) begin
            errors++; $display("FAIL ignore_stray_result: got done=%0d err=%0d want 0 0", done_hi, err_hi);
        end
        if (n_start !== NB) begin errors++; $display("FAIL ignore_start_count: got %0d want %0d", n_start, NB); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL ignore_byte[%0d]: got none want %h", k, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL ignore_byte[%0d]: got %h want %h", k, o, e); end
            end
        end
        res_q.push_back(5);
        send_rx(8'h05);
        repeat (4) @(negedge clk);
        checks += 2;
        if (done_hi !== 1) begin errors++; $display("FAIL ignore_done: got %0d want 1", done_hi); end
        if (int'(digit) !== res_q.pop_front()) begin errors++; $display("FAIL ignore_digit: got %0d want 5", digit); end
    endtask

    task automatic test_pattern_bad_result();
        bit ok;
        int blo, t;
        logic [7:0] e, o;
        for (int a = 0; a < 1024; a++) img[a] = (a % 8 == 0) || (a == 783);
        // Pixels above 783 are set, so a read past the image end would corrupt the last byte.
        for (int a = 784; a < 1024; a++) img[a] = 1'b1;
        exp_q.delete();
        obs_q.delete();
        for (int k = 0; k < NB - 1; k++) exp_q.push_back(8'h01);
        exp_q.push_back(8'h81);
        n_start = 0; done_hi = 0; err_hi = 0; max_addr = 0;
        drive_start();
        wait_bytes(NB, ok, blo);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL pattern_tx_timeout: got %0d bytes want %0d", n_start, NB); end
        if (max_addr !== 783) begin errors++; $display("FAIL pattern_max_addr: got %0d want 783", max_addr); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL pattern_byte[%0d]: got none want %h", k, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL pattern_byte[%0d]: got %h want %h", k, o, e); end
            end
        end
        repeat (5) @(negedge clk);
        send_rx(8'h0C);
        t = 0;
        while (err_hi == 0 && t < 50) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        checks += 4;
        if (err_hi !== 1)   begin errors++; $display("FAIL bad_result_err: got %0d want 1", err_hi); end
        if (done_hi !== 0)  begin errors++; $display("FAIL bad_result_done: got %0d want 0", done_hi); end
        if (digit !== 4'hF) begin errors++; $display("FAIL bad_result_digit: got %h want F", digit); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL bad_result_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int t, held;
        for (int a = 0; a < 1024; a++) img[a] = 1'($urandom_range(0, 1));
        load_expected();
        drive_start();
        t = 0;
        while (n_start < 40 && t < 4000) begin @(negedge clk); t++; end
        checks++;
        if (n_start < 40) begin errors++; $display("FAIL mid_reach_byte40: got %0d want 40", n_start); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (mem_addr !== 10'd0) begin errors++; $display("FAIL mid_mem_addr: got %0d want 0", mem_addr); end
        if (tx_start !== 1'b0)  begin errors++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
        if (tx_data !== 8'h00)  begin errors++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL mid_done: got %b want 0", done); end
        if (err !== 1'b0)       begin errors++; $display("FAIL mid_err: got %b want 0", err); end
        if (digit !== 4'hF)     begin errors++; $display("FAIL mid_digit: got %h want F", digit); end
        @(negedge clk) rst_n = 1'b1;
        held = n_start;
        repeat (400) @(negedge clk);
        checks += 2;
        if (n_start !== held) begin errors++; $display("FAIL mid_no_resume: got %0d starts want %0d", n_start, held); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy: got %b want 0", busy); end
        obs_q.delete();
        drive_start();
        t = 0;
        while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL restart_first_byte: got none want %h", pack_byte(0));
        end else if (obs_q[0] !== pack_byte(0)) begin
            errors++; $display("FAIL restart_first_byte: got %h want %h", obs_q[0], pack_byte(0));
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) img[a] = 1'b0;
        test_reset();
        test_snn_result();
        test_all_zero_timeout();
        test_ignore_while_busy();
        test_pattern_bad_result();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
